// File: rtl/knn_merge_topk.sv
// Merges two ascending top-K candidate lists into the K globally smallest words per batch.
// Define KNN_MERGE_STATUS_EN to add the per-batch status word on Output_2.
module knn_merge_topk #(
    parameter int unsigned K          = 8,
    parameter int unsigned DIST_BITS  = 24,
    parameter int unsigned LABEL_BITS = 8
) (
    input  logic                              ap_clk,
    input  logic                              ap_rst_n,
    input  logic [DIST_BITS+LABEL_BITS-1:0]   Input_1_V_V,
    input  logic                              Input_1_V_V_ap_vld,
    output logic                              Input_1_V_V_ap_ack,
    input  logic [DIST_BITS+LABEL_BITS-1:0]   Input_2_V_V,
    input  logic                              Input_2_V_V_ap_vld,
    output logic                              Input_2_V_V_ap_ack,
    output logic [DIST_BITS+LABEL_BITS-1:0]   Output_1_V_V,
    output logic                              Output_1_V_V_ap_vld,
    input  logic                              Output_1_V_V_ap_ack,
    output logic [DIST_BITS+LABEL_BITS-1:0]   Output_2_V_V,
    output logic                              Output_2_V_V_ap_vld,
    input  logic                              Output_2_V_V_ap_ack
);
    localparam int unsigned   W  = DIST_BITS + LABEL_BITS;
    localparam int unsigned   CW = $clog2(K + 1);
    localparam logic [CW-1:0] KC = CW'(K);

    typedef enum logic [1:0] {
        S_MERGE  = 2'd0,
        S_DRAIN  = 2'd1
`ifdef KNN_MERGE_STATUS_EN
        , S_STATUS = 2'd2
`endif
    } state_t;

    state_t          r_state, w_next;
    logic [W-1:0]    r_h1, r_h2, r_out;
    logic            r_h1_vld, r_h2_vld, r_out_vld;
    logic [CW-1:0]   r_rx1, r_rx2, r_tk1, r_tk2, r_ne;
    logic [15:0]     r_bc;

    logic w_acc1, w_acc2, w_exh1, w_exh2, w_out_free;
    logic w_h1_le, w_pick1, w_pick2, w_do_pick, w_batch_done, w_in_open;

    assign w_acc1     = Input_1_V_V_ap_vld & Input_1_V_V_ap_ack;
    assign w_acc2     = Input_2_V_V_ap_vld & Input_2_V_V_ap_ack;
    assign w_exh1     = (r_rx1 == KC) & ~r_h1_vld;
    assign w_exh2     = (r_rx2 == KC) & ~r_h2_vld;
    assign w_out_free = ~r_out_vld | Output_1_V_V_ap_ack;
    // Distances compare unsigned; equal distances favour list 1.
    assign w_h1_le    = r_h1[W-1:LABEL_BITS] <= r_h2[W-1:LABEL_BITS];
    assign w_pick1    = r_h1_vld & (r_h2_vld ? w_h1_le  : w_exh2);
    assign w_pick2    = r_h2_vld & (r_h1_vld ? ~w_h1_le : w_exh1);
    assign w_do_pick  = (r_state == S_MERGE) & w_out_free & (w_pick1 | w_pick2);

`ifdef KNN_MERGE_STATUS_EN
    assign w_batch_done = (r_state == S_STATUS) & Output_2_V_V_ap_ack;
`else
    assign w_batch_done = (r_state == S_DRAIN) & w_exh1 & w_exh2;
    logic w_unused_o2_ack;
    assign w_unused_o2_ack = Output_2_V_V_ap_ack;
`endif

    always_ff @(posedge ap_clk or negedge ap_rst_n) begin
        if (!ap_rst_n) r_state <= S_MERGE;
        else           r_state <= w_next;
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_MERGE: if (w_do_pick && (r_ne == KC - CW'(1))) w_next = S_DRAIN;
            S_DRAIN: begin
                if (w_exh1 && w_exh2) begin
`ifdef KNN_MERGE_STATUS_EN
                    w_next = S_STATUS;
`else
                    w_next = S_MERGE;
`endif
                end
            end
`ifdef KNN_MERGE_STATUS_EN
            S_STATUS: if (Output_2_V_V_ap_ack) w_next = S_MERGE;
`endif
            default: w_next = S_MERGE;
        endcase
    end

    // Input acks are gated by reset so they drop the instant reset asserts.
    always_comb begin
        w_in_open           = ap_rst_n & ((r_state == S_MERGE) | (r_state == S_DRAIN));
        Input_1_V_V_ap_ack  = w_in_open & Input_1_V_V_ap_vld & ~r_h1_vld & (r_rx1 < KC);
        Input_2_V_V_ap_ack  = w_in_open & Input_2_V_V_ap_vld & ~r_h2_vld & (r_rx2 < KC);
        Output_2_V_V_ap_vld = 1'b0;
        Output_2_V_V        = '0;
`ifdef KNN_MERGE_STATUS_EN
        if (r_state == S_STATUS) begin
            Output_2_V_V_ap_vld = 1'b1;
            Output_2_V_V        = W'({r_bc, 8'(r_tk1), 8'(r_tk2)});
        end
`endif
    end

    always_ff @(posedge ap_clk or negedge ap_rst_n) begin
        if (!ap_rst_n) begin
            r_h1     <= '0;
            r_h2     <= '0;
            r_h1_vld <= 1'b0;
            r_h2_vld <= 1'b0;
        end else begin
            if (w_acc1) begin
                r_h1     <= Input_1_V_V;
                r_h1_vld <= 1'b1;
            end else if ((w_do_pick && w_pick1) || (r_state == S_DRAIN)) begin
                r_h1_vld <= 1'b0;
            end
            if (w_acc2) begin
                r_h2     <= Input_2_V_V;
                r_h2_vld <= 1'b1;
            end else if ((w_do_pick && w_pick2) || (r_state == S_DRAIN)) begin
                r_h2_vld <= 1'b0;
            end
        end
    end

    always_ff @(posedge ap_clk or negedge ap_rst_n) begin
        if (!ap_rst_n) begin
            r_rx1 <= '0;
            r_rx2 <= '0;
            r_tk1 <= '0;
            r_tk2 <= '0;
            r_ne  <= '0;
            r_bc  <= '0;
        end else if (w_batch_done) begin
            r_rx1 <= '0;
            r_rx2 <= '0;
            r_tk1 <= '0;
            r_tk2 <= '0;
            r_ne  <= '0;
            r_bc  <= r_bc + 16'd1;
        end else begin
            if (w_acc1) r_rx1 <= r_rx1 + CW'(1);
            if (w_acc2) r_rx2 <= r_rx2 + CW'(1);
            if (w_do_pick) begin
                r_ne <= r_ne + CW'(1);
                if (w_pick1) r_tk1 <= r_tk1 + CW'(1);
                else         r_tk2 <= r_tk2 + CW'(1);
            end
        end
    end

    // A pick may overwrite the word being acked in the same cycle.
    always_ff @(posedge ap_clk or negedge ap_rst_n) begin
        if (!ap_rst_n) begin
            r_out     <= '0;
            r_out_vld <= 1'b0;
        end else if (w_do_pick) begin
            r_out     <= w_pick1 ? r_h1 : r_h2;
            r_out_vld <= 1'b1;
        end else if (Output_1_V_V_ap_ack) begin
            r_out_vld <= 1'b0;
        end
    end

    assign Output_1_V_V        = r_out;
    assign Output_1_V_V_ap_vld = r_out_vld;

endmodule

// File: tb/tb_knn_merge_topk.sv
// Directed bench for knn_merge_topk with K=4: table of batches plus latency, backpressure and reset sequences.
module tb_knn_merge_topk;
    localparam int K_T = 4;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [31:0] i1_data = '0, i2_data = '0;
    logic        i1_vld = 1'b0, i2_vld = 1'b0;
    logic        i1_ack, i2_ack;
    logic [31:0] o1_data, o2_data;
    logic        o1_vld, o2_vld;
    logic        o1_ack;
    logic        o2_ack = 1'b1;

    int          checks = 0;
    int          failures = 0;
    logic [31:0] o1_q[$];
    logic [31:0] o2_q[$];
    int          o2_seen = 0;
    int          stall_at = -1;
    int          stall_left = 0;
    bit          held_set = 1'b0;
    logic [31:0] held = '0;
    bit          o1_hold = 1'b0;
    logic [31:0] src1[K_T];
    logic [31:0] src2[K_T];

    typedef struct {
        logic [31:0] l1[K_T];
        logic [31:0] l2[K_T];
        logic [31:0] exp[K_T];
        logic [31:0] st;
        bit          bp;
    } vec_t;
    vec_t vt[5];

    knn_merge_topk #(.K(4), .DIST_BITS(24), .LABEL_BITS(8)) dut (
        .ap_clk              (clk),
        .ap_rst_n            (rst_n),
        .Input_1_V_V         (i1_data),
        .Input_1_V_V_ap_vld  (i1_vld),
        .Input_1_V_V_ap_ack  (i1_ack),
        .Input_2_V_V         (i2_data),
        .Input_2_V_V_ap_vld  (i2_vld),
        .Input_2_V_V_ap_ack  (i2_ack),
        .Output_1_V_V        (o1_data),
        .Output_1_V_V_ap_vld (o1_vld),
        .Output_1_V_V_ap_ack (o1_ack),
        .Output_2_V_V        (o2_data),
        .Output_2_V_V_ap_vld (o2_vld),
        .Output_2_V_V_ap_ack (o2_ack)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] mk(input int d, input int l);
        logic [31:0] dv, lv;
        dv = d;
        lv = l;
        return {dv[23:0], lv[7:0]};
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    // Sink: acks Output_1 unless held or stalled, records every transfer.
    always @(negedge clk) begin
        if (stall_at >= 0 && o1_q.size() == stall_at) begin
            stall_left = 10;
            stall_at   = -1;
            held_set   = 1'b0;
        end
        o1_ack = !o1_hold && (stall_left == 0);
        #1;
        if (stall_left > 0) begin
            if (held_set) begin
                chk("bp_vld_hold", {31'b0, o1_vld}, 32'd1);
                chk("bp_data_hold", o1_data, held);
            end else if (o1_vld) begin
                held     = o1_data;
                held_set = 1'b1;
            end
            if (stall_left == 1) begin
                if (i1_vld) chk("bp_in1_blocked", {31'b0, i1_ack}, 32'd0);
                if (i2_vld) chk("bp_in2_blocked", {31'b0, i2_ack}, 32'd0);
            end
            stall_left--;
        end
        if (o1_vld && o1_ack) o1_q.push_back(o1_data);
        if (o2_vld) o2_seen++;
        if (o2_vld && o2_ack) o2_q.push_back(o2_data);
    end

    task automatic feed(input int side);
        for (int i = 0; i < K_T; i++) begin
            int guard;
            guard = 0;
            @(negedge clk);
            if (side == 1) begin i1_data = src1[i]; i1_vld = 1'b1; end
            else           begin i2_data = src2[i]; i2_vld = 1'b1; end
            #1;
            while (!((side == 1) ? i1_ack : i2_ack)) begin
                guard++;
                if (guard > 300) begin
                    checks++;
                    failures++;
                    $display("FAIL feed%0d_timeout word=%0d got ack=0 expected ack=1", side, i);
                    if (side == 1) i1_vld = 1'b0; else i2_vld = 1'b0;
                    return;
                end
                @(negedge clk);
                #1;
            end
            @(posedge clk);
        end
        @(negedge clk);
        if (side == 1) i1_vld = 1'b0; else i2_vld = 1'b0;
    endtask

    task automatic wait_q(input int target, input bit is_st);
        int guard;
        guard = 0;
        while (((is_st ? o2_q.size() : o1_q.size()) < target) && guard < 400) begin
            @(negedge clk);
            guard++;
        end
    endtask

    task automatic run_batch(input int idx);
        int base, sbase;
        base  = o1_q.size();
        sbase = o2_q.size();
        for (int i = 0; i < K_T; i++) begin
            src1[i] = vt[idx].l1[i];
            src2[i] = vt[idx].l2[i];
        end
        if (vt[idx].bp) stall_at = base + 2;
        fork
            feed(1);
            feed(2);
        join
        wait_q(base + K_T, 1'b0);
`ifdef KNN_MERGE_STATUS_EN
        wait_q(sbase + 1, 1'b1);
`endif
        repeat (3) @(negedge clk);
        chk($sformatf("b%0d_count", idx), o1_q.size(), base + K_T);
        for (int i = 0; i < K_T; i++)
            chk($sformatf("b%0d_word%0d", idx, i),
                (o1_q.size() > base + i) ? o1_q[base + i] : 32'hFFFF_FFFF, vt[idx].exp[i]);
`ifdef KNN_MERGE_STATUS_EN
        chk($sformatf("b%0d_status", idx),
            (o2_q.size() > sbase) ? o2_q[sbase] : 32'hFFFF_FFFF, vt[idx].st);
`endif
    endtask

    initial begin
        vt[0].l1  = '{mk(1, 'h10), mk(3, 'h11), mk(5, 'h12), mk(7, 'h13)};
        vt[0].l2  = '{mk(2, 'h20), mk(4, 'h21), mk(6, 'h22), mk(8, 'h23)};
        vt[0].exp = '{mk(1, 'h10), mk(2, 'h20), mk(3, 'h11), mk(4, 'h21)};
        vt[0].st  = 32'h0000_0202;
        vt[0].bp  = 1'b0;
        vt[1].l1  = '{mk(5, 'hA), mk(5, 'hA), mk(9, 'hA), mk(9, 'hA)};
        vt[1].l2  = '{mk(5, 'hB), mk(6, 'hB), mk(6, 'hB), mk(6, 'hB)};
        vt[1].exp = '{mk(5, 'hA), mk(5, 'hA), mk(5, 'hB), mk(6, 'hB)};
        vt[1].st  = 32'h0001_0202;
        vt[1].bp  = 1'b0;
        vt[2].l1  = '{mk(1, 'h31), mk(2, 'h32), mk(3, 'h33), mk(4, 'h34)};
        vt[2].l2  = '{mk(10, 'h41), mk(11, 'h42), mk(12, 'h43), mk(13, 'h44)};
        vt[2].exp = '{mk(1, 'h31), mk(2, 'h32), mk(3, 'h33), mk(4, 'h34)};
        vt[2].st  = 32'h0002_0400;
        vt[2].bp  = 1'b0;
        vt[3].l1  = '{mk(20, 'h51), mk(21, 'h52), mk(22, 'h53), mk(23, 'h54)};
        vt[3].l2  = '{mk(0, 'h61), mk(0, 'h62), mk(1, 'h63), mk(2, 'h64)};
        vt[3].exp = '{mk(0, 'h61), mk(0, 'h62), mk(1, 'h63), mk(2, 'h64)};
        vt[3].st  = 32'h0003_0004;
        vt[3].bp  = 1'b1;
        vt[4].l1  = '{mk('h7FFFFF, 1), mk('h800000, 2), mk('hFFFFFF, 3), mk('hFFFFFF, 4)};
        vt[4].l2  = '{mk('h800000, 5), mk('h800001, 6), mk('hFFFFFF, 7), mk('hFFFFFF, 8)};
        vt[4].exp = '{mk('h7FFFFF, 1), mk('h800000, 2), mk('h800000, 5), mk('h800001, 6)};
        vt[4].st  = 32'h0004_0202;
        vt[4].bp  = 1'b0;

        // Reset state, with a pending input word that must not be acked.
        i1_data = mk(1, 1);
        i1_vld  = 1'b1;
        repeat (2) @(negedge clk);
        #1;
        chk("rst_o1_vld", {31'b0, o1_vld}, 32'd0);
        chk("rst_o1_data", o1_data, 32'd0);
        chk("rst_o2_vld", {31'b0, o2_vld}, 32'd0);
        chk("rst_o2_data", o2_data, 32'd0);
        chk("rst_i1_ack", {31'b0, i1_ack}, 32'd0);
        i1_vld = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;

        for (int b = 0; b < 5; b++) run_batch(b);

        // Latency: both words accepted at t, output valid at t+2; then async reset mid-merge.
        o1_hold = 1'b1;
        @(negedge clk);
        i1_data = mk(9, 'h71); i1_vld = 1'b1;
        i2_data = mk(3, 'h72); i2_vld = 1'b1;
        #1;
        chk("lat_i1_ack", {31'b0, i1_ack}, 32'd1);
        chk("lat_i2_ack", {31'b0, i2_ack}, 32'd1);
        @(negedge clk);
        i1_vld = 1'b0;
        i2_vld = 1'b0;
        #1;
        chk("lat_t1_vld", {31'b0, o1_vld}, 32'd0);
        @(negedge clk);
        #1;
        chk("lat_t2_vld", {31'b0, o1_vld}, 32'd1);
        chk("lat_t2_data", o1_data, mk(3, 'h72));
        i2_data = mk(4, 'h73);
        i2_vld  = 1'b1;
        #1;
        chk("pre_rst_i2_ack", {31'b0, i2_ack}, 32'd1);
        #1 rst_n = 1'b0;
        #1;
        chk("async_rst_o1_vld", {31'b0, o1_vld}, 32'd0);
        chk("async_rst_o1_data", o1_data, 32'd0);
        chk("async_rst_i2_ack", {31'b0, i2_ack}, 32'd0);
        chk("async_rst_o2_vld", {31'b0, o2_vld}, 32'd0);
        @(negedge clk);
        i2_vld = 1'b0;
        @(negedge clk);
        rst_n   = 1'b1;
        o1_hold = 1'b0;

        // Fresh batch after reset: batch counter restarts from zero.
        run_batch(0);
        run_batch(1);

`ifndef KNN_MERGE_STATUS_EN
        chk("o2_never_vld", o2_seen, 32'd0);
`endif
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule

// File: doc/knn_merge_topk.md
# knn_merge_topk

Downstream stage of the update_knn_cluster operators in the KNN leaf pipeline. Consumes two sorted top-K candidate lists, one per input stream, each ascending by distance. Streams out the K globally smallest candidates of each batch on Output_1. When compiled in, it also emits one per-batch status word on Output_2. All ports use the ap_vld/ap_ack stream handshake that the leaf interface and the HLS operators use.

## Interface
- K, 8: candidates per input list and per output batch; legal range 2..255.
- DIST_BITS, 24: distance field width, word bits [31:8]; unsigned.
- LABEL_BITS, 8: label field width, word bits [7:0]; DIST_BITS+LABEL_BITS = 32.

Ports:
- ap_clk  in  1  single clock; all state on rising edge.
- ap_rst_n  in  1  reset; asynchronous, active-low.
- Input_1_V_V  in  32  candidate word from list 1.
- Input_1_V_V_ap_vld  in  1  word valid.
- Input_1_V_V_ap_ack  out  1  word consumed this cycle.
- Input_2_V_V / _ap_vld / _ap_ack: same as Input_1, for list 2.
- Output_1_V_V  out  32  merged candidate word.
- Output_1_V_V_ap_vld  out  1  output word valid.
- Output_1_V_V_ap_ack  in  1  downstream accepted the output word.
- Output_2_V_V  out  32  status word.
- Output_2_V_V_ap_vld  out  1  status valid.
- Output_2_V_V_ap_ack  in  1  downstream accepted the status word.

## Operation
- A transfer occurs on any cycle where vld and ack are both high. ack is combinational from vld and internal state. A source holds vld and data stable until the transfer.
- Internal state:
  - Head registers h1/h2, each with a valid flag.
  - Receive counters rx1/rx2, range 0..K.
  - Taken counters tk1/tk2 and emit counter ne, range 0..K.
  - Batch counter bc, 16 bits, wraps at 0xFFFF to 0.
  - Output register with a valid flag.
- Input_X_ack = Input_X_vld & ~hX_valid & (rxX < K) & state ∈ {MERGE, DRAIN}. A transfer loads hX, sets hX_valid and increments rxX.
- Side X is exhausted when rxX == K and hX_valid == 0.
- States: MERGE, DRAIN, STATUS.
- MERGE: selection happens when the output register is free, or is freed by an ack this cycle.
  - If both heads are valid, pick the head with the smaller distance. Ties go to Input_1.
  - If one side is exhausted and the other head is valid, pick the valid head.
  - Otherwise wait.
  - On a pick: copy the head to the output register, clear its valid flag, increment tkX and ne.
  - When ne reaches K, go to DRAIN.
- DRAIN: discard any valid head, and accept and discard remaining input words, until both sides are exhausted.
  - Output_1 may still be waiting for its ack.
  - When both sides are exhausted: go to STATUS if the status feature is enabled; otherwise clear the counters, increment bc and go to MERGE.
- STATUS: assert Output_2 with {bc[15:0], tk1[7:0], tk2[7:0]} and hold until acked.
  - On ack: clear rx/tk/ne, increment bc, go to MERGE.
  - Input acks stay low in STATUS.
- Reset mid-batch discards all partial state. No output is replayed.

## Timing
- Reset values:
  - All ack and vld outputs: 0.
  - Output_1_V_V and Output_2_V_V: 0.
  - Heads invalid; counters 0; bc = 0; state MERGE.
- Latency: a word accepted at cycle t is in the head at t+1. If it is selected at t+1, Output_1_vld is high at t+2.
- Throughput: one Output_1 word per cycle in MERGE while Output_1_ack stays high and the chosen side refills its head every other cycle. Sustained rate is at least one word per 2 cycles.
- Output_1 data is stable while vld=1 and ack=0. A new word may replace the accepted one in the same cycle as the ack, giving back-to-back transfers.
- Simultaneous events:
  - A head refill and a pick from the other head in the same cycle are both allowed.
  - The Output_1 ack and a new pick in the same cycle are both allowed.
- Boundaries:
  - rxX == K blocks Input_X ack until the next batch.
  - A list that is not sorted is not detected; the output is then unspecified ordering but still exactly K words.

## Configuration
- KNN_MERGE_STATUS_EN defined: STATUS state exists and one Output_2 word is emitted per batch as above.
- KNN_MERGE_STATUS_EN undefined:
  - STATUS state is removed.
  - Output_2_V_V_ap_vld is tied to 0 and Output_2_V_V to 0; Output_2_V_V_ap_ack is ignored.
  - DRAIN returns directly to MERGE.

## Test plan
- K=4, L1 distances 1,3,5,7, L2 distances 2,4,6,8, sink always acks → Output_1 emits distances 1,2,3,4, then Output_2 = 0x0000_0202.
- Tie: L1 = {5,5,9,9} labels 0xA, L2 = {5,6,6,6} labels 0xB → Output_1 emits 5/A, 5/A, 5/B, 6/B.
- Backpressure: Output_1_ack low for 10 cycles mid-batch → data and vld held constant, no word lost or duplicated, and inputs stall once both heads are full.
- Exhaust one side: L1 = {1,2,3,4}, L2 = {10,11,12,13} → Output_1 emits 1..4 and status tk1=4, tk2=0. All 4 L2 words are acked and discarded before the next batch.
- Assert ap_rst_n low asynchronously mid-MERGE → outputs and acks go to 0 immediately. After release, a fresh batch produces correct results with bc = 0.
- Build without KNN_MERGE_STATUS_EN, 3 consecutive batches → Output_2_vld never asserts and batches run back-to-back.
